seg7_scan_driver: RTL and testbench

- Downstream display stage for the decade counters.
- Captures DIGITS packed BCD nibbles and time-multiplexes them onto one shared 7-segment bus with active-low digit anodes.
- Adds optional leading-zero blanking, a one-cycle inter-digit dead time to suppress ghosting, and an invalid-code flag.
- Sits between the counter chain and the board display pins.

---
 rtl/seg7_scan_driver.sv | 122 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: captures packed BCD digits and scans them
// onto a shared segment bus with one dead cycle per digit slot.
module seg7_scan_driver #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter bit          ACTIVE_LOW_SEG = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [4*DIGITS-1:0]   BCD_IN,
    input  logic                  LOAD,
    input  logic                  BLANK_EN,
    output logic [6:0]            SEG,
    output logic [DIGITS-1:0]     AN,
    output logic                  ERR
);

    localparam int unsigned   PW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned   IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [6:0]    SEG_OFF = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
    localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] I_LAST  = IW'(DIGITS - 1);

    logic [4*DIGITS-1:0] shadow;
    logic [PW-1:0]       p;
    logic [IW-1:0]       idx;

    logic [DIGITS-1:0]   blank_mask;
    logic                zero_run;
    logic [3:0]          cur_nib;
    logic                cur_blank;
    logic [6:0]          seg_act;
    logic [6:0]          seg_nxt;
    logic [DIGITS-1:0]   an_nxt;
    logic                err_nxt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shadow <= '0;
        end else if (LOAD) begin
            shadow <= BCD_IN;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            p   <= '0;
            idx <= '0;
        end else if (p == P_LAST) begin
            p   <= '0;
            idx <= (idx == I_LAST) ? '0 : idx + 1'b1;
        end else begin
            p   <= p + 1'b1;
        end
    end

    // Walk from the most significant digit down; a digit is blank while every
    // digit at or above it is zero. Digit 0 always shows.
    always_comb begin
        blank_mask = '0;
        zero_run   = 1'b1;
        for (int unsigned j = 0; j < DIGITS; j++) begin
            zero_run = zero_run & (shadow[4*(DIGITS-1-j) +: 4] == 4'd0);
            blank_mask[DIGITS-1-j] = zero_run && ((DIGITS-1-j) != 0);
        end
    end

    always_comb begin
        cur_nib   = '0;
        cur_blank = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_nib   = shadow[4*k +: 4];
                cur_blank = blank_mask[k];
            end
        end
    end

    always_comb begin
        seg_act = 7'h40;
        case (cur_nib)
            4'd0:    seg_act = 7'h3F;
            4'd1:    seg_act = 7'h06;
            4'd2:    seg_act = 7'h5B;
            4'd3:    seg_act = 7'h4F;
            4'd4:    seg_act = 7'h66;
            4'd5:    seg_act = 7'h6D;
            4'd6:    seg_act = 7'h7D;
            4'd7:    seg_act = 7'h07;
            4'd8:    seg_act = 7'h7F;
            4'd9:    seg_act = 7'h6F;
            default: seg_act = 7'h40;
        endcase
        if (BLANK_EN && cur_blank) begin
            seg_act = 7'h00;
        end
        seg_nxt = ACTIVE_LOW_SEG ? ~seg_act : seg_act;
    end

    always_comb begin
        an_nxt  = (p == '0) ? '1 : ~(DIGITS'(1) << idx);
        err_nxt = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (shadow[4*k +: 4] > 4'd9) begin
                err_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            SEG <= SEG_OFF;
            AN  <= '1;
            ERR <= 1'b0;
        end else begin
            SEG <= seg_nxt;
            AN  <= an_nxt;
            ERR <= err_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a 4-digit active-low instance and a 1-digit
// active-high instance checked against a cycle-count based reference model.
module tb_seg7_scan_driver;

    localparam int RD = 4;
    localparam logic [6:0] LUT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bcd;
    logic        load, blank_en;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        err;
    logic [3:0]  bcd1;
    logic        load1, blank1;
    logic [6:0]  seg1;
    logic [0:0]  an1;
    logic        err1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(RD), .ACTIVE_LOW_SEG(1'b1)) dut (
        .CLK(clk), .RST_N(rst_n), .BCD_IN(bcd), .LOAD(load), .BLANK_EN(blank_en),
        .SEG(seg), .AN(an), .ERR(err)
    );

    seg7_scan_driver #(.DIGITS(1), .REFRESH_DIV(RD), .ACTIVE_LOW_SEG(1'b0)) dut1 (
        .CLK(clk), .RST_N(rst_n), .BCD_IN(bcd1), .LOAD(load1), .BLANK_EN(blank1),
        .SEG(seg1), .AN(an1), .ERR(err1)
    );

    function automatic logic [6:0] pattern(logic [31:0] sh, int k, logic be, bit al);
        logic [3:0] nib;
        logic [6:0] v;
        nib = 4'((sh >> (4*k)) & 32'hF);
        if (be && k > 0 && (sh >> (4*k)) == 0) v = 7'h00;
        else if (nib > 9)                      v = 7'h40;
        else                                   v = LUT[nib];
        return al ? ~v : v;
    endfunction

    function automatic logic any_invalid(logic [31:0] sh, int d);
        for (int k = 0; k < d; k++)
            if (((sh >> (4*k)) & 32'hF) > 9) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: position in the scan is derived from cycles since reset.
    int          cyc0, cyc1, p0, i0;
    logic [15:0] msh0;
    logic [3:0]  msh1;
    logic [3:0]  exp_an0;
    logic [6:0]  exp_seg0;
    logic        exp_err0;
    logic [0:0]  exp_an1;
    logic [6:0]  exp_seg1;
    logic        exp_err1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc0 = 0; msh0 = '0; exp_an0 = 4'hF; exp_seg0 = 7'h7F; exp_err0 = 1'b0;
            cyc1 = 0; msh1 = '0; exp_an1 = 1'b1; exp_seg1 = 7'h00; exp_err1 = 1'b0;
        end else begin
            p0 = cyc0 % RD;
            i0 = (cyc0 / RD) % 4;
            exp_an0  = (p0 == 0) ? 4'hF : ~(4'b0001 << i0);
            exp_seg0 = pattern(32'(msh0), i0, blank_en, 1'b1);
            exp_err0 = any_invalid(32'(msh0), 4);
            if (load) msh0 = bcd;
            cyc0++;
            exp_an1  = (cyc1 % RD == 0) ? 1'b1 : 1'b0;
            exp_seg1 = pattern(32'(msh1), 0, blank1, 1'b0);
            exp_err1 = any_invalid(32'(msh1), 1);
            if (load1) msh1 = bcd1;
            cyc1++;
        end
    end

    task automatic test_reset;
        #12;
        checks++; if (an !== 4'hF)  begin errors++; $display("FAIL reset_an got=%h exp=%h", an, 4'hF); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got=%h exp=%h", seg, 7'h7F); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (an1 !== 1'b1) begin errors++; $display("FAIL reset_an1 got=%b exp=1", an1); end
        checks++; if (seg1 !== 7'h00) begin errors++; $display("FAIL reset_seg1 got=%h exp=00", seg1); end
        checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL reset_err1 got=%b exp=0", err1); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_scan_idle;
        logic [3:0] tbl [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                                 4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            checks++;
            if (an !== tbl[n % 16]) begin
                errors++; $display("FAIL idle_an n=%0d got=%h exp=%h", n, an, tbl[n % 16]);
            end
            if (an !== 4'hF) begin
                checks++;
                if (seg !== 7'h40) begin errors++; $display("FAIL idle_seg n=%0d got=%h exp=40", n, seg); end
            end
            checks++;
            if (an1 !== ((n % 4 == 0) ? 1'b1 : 1'b0) || seg1 !== 7'h3F || err1 !== 1'b0 || err !== 1'b0) begin
                errors++; $display("FAIL idle_misc n=%0d got an1=%b seg1=%h err=%b err1=%b exp an1=%b seg1=3f err=0 err1=0",
                                   n, an1, seg1, err, err1, (n % 4 == 0));
            end
        end
    endtask

    typedef struct packed {
        logic [15:0] bcd;
        logic        be;
        logic        err;
        logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    task automatic test_load_vectors;
        vec_t vecs [5] = '{
            '{16'h1234, 1'b0, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}},
            '{16'h0007, 1'b1, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h78}},
            '{16'h0000, 1'b1, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h40}},
            '{16'h0A05, 1'b1, 1'b1, {7'h7F, 7'h3F, 7'h40, 7'h12}},
            '{16'h0005, 1'b1, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h12}}
        };
        logic prev_err;
        logic [6:0] want;
        prev_err = 1'b0;
        foreach (vecs[v]) begin
            @(negedge clk);
            load = 1'b1; bcd = vecs[v].bcd; blank_en = vecs[v].be;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                load = 1'b0;
                checks++;
                if ({an, seg, err} !== {exp_an0, exp_seg0, exp_err0}) begin
                    errors++; $display("FAIL vec%0d_model k=%0d got an=%h seg=%h err=%b exp an=%h seg=%h err=%b",
                                       v, k, an, seg, err, exp_an0, exp_seg0, exp_err0);
                end
                if (k < 2) begin
                    checks++;
                    if (err !== ((k == 0) ? prev_err : vecs[v].err)) begin
                        errors++; $display("FAIL vec%0d_err_latency k=%0d got=%b exp=%b",
                                           v, k, err, (k == 0) ? prev_err : vecs[v].err);
                    end
                end else if (an !== 4'hF) begin
                    want = 7'hxx;
                    for (int d = 0; d < 4; d++)
                        if (an === ~(4'b0001 << d)) want = vecs[v].segs[7*d +: 7];
                    checks++;
                    if (seg !== want) begin
                        errors++; $display("FAIL vec%0d_seg an=%h got=%h exp=%h", v, an, seg, want);
                    end
                end
            end
            prev_err = vecs[v].err;
        end
    endtask

    task automatic test_single_digit;
        logic [3:0] vals [2] = '{4'h8, 4'h0};
        int ones;
        foreach (vals[v]) begin
            @(negedge clk);
            load1 = 1'b1; bcd1 = vals[v]; blank1 = 1'b1;
            ones = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                load1 = 1'b0;
                checks++;
                if ({an1, seg1, err1} !== {exp_an1, exp_seg1, exp_err1}) begin
                    errors++; $display("FAIL single_model k=%0d got an1=%b seg1=%h err1=%b exp an1=%b seg1=%h err1=%b",
                                       k, an1, seg1, err1, exp_an1, exp_seg1, exp_err1);
                end
                if (k >= 2) begin
                    ones += (an1 === 1'b1) ? 1 : 0;
                    if (an1 === 1'b0) begin
                        checks++;
                        if (seg1 !== ((v == 0) ? 7'h7F : 7'h3F)) begin
                            errors++; $display("FAIL single_seg v=%0d got=%h exp=%h", v, seg1, (v == 0) ? 7'h7F : 7'h3F);
                        end
                    end
                end
            end
            checks++;
            if (ones != 2) begin errors++; $display("FAIL single_duty got=%0d exp=2", ones); end
        end
    endtask

    task automatic test_random;
        logic [15:0] r;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, err} !== {exp_an0, exp_seg0, exp_err0}) begin
                errors++; $display("FAIL rand_model n=%0d got an=%h seg=%h err=%b exp an=%h seg=%h err=%b",
                                   n, an, seg, err, exp_an0, exp_seg0, exp_err0);
            end
            checks++;
            if ({an1, seg1, err1} !== {exp_an1, exp_seg1, exp_err1}) begin
                errors++; $display("FAIL rand_model1 n=%0d got an1=%b seg1=%h err1=%b exp an1=%b seg1=%h err1=%b",
                                   n, an1, seg1, err1, exp_an1, exp_seg1, exp_err1);
            end
            for (int d = 0; d < 4; d++)
                r[4*d +: 4] = ($urandom % 8 == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            r = r & (16'hFFFF >> (4 * $urandom_range(0, 4)));
            load     = ($urandom % 3 == 0);
            bcd      = r;
            blank_en = $urandom % 2;
            load1    = ($urandom % 3 == 0);
            bcd1     = 4'($urandom_range(0, 15));
            blank1   = $urandom % 2;
        end
        load = 1'b0; load1 = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit found;
        @(negedge clk);
        load = 1'b1; bcd = 16'h0A05; blank_en = 1'b0;
        @(negedge clk);
        load = 1'b0;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (an === 4'b1011) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL midreset_wait got=timeout exp=digit2_slot"); end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL midreset_pre_err got=%b exp=1", err); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || err !== 1'b0) begin
            errors++; $display("FAIL midreset_async got an=%h seg=%h err=%b exp an=f seg=7f err=0", an, seg, err);
        end
        checks++;
        if (an1 !== 1'b1 || seg1 !== 7'h00 || err1 !== 1'b0) begin
            errors++; $display("FAIL midreset_async1 got an1=%b seg1=%h err1=%b exp an1=1 seg1=00 err1=0", an1, seg1, err1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (an !== ((k == 0 || k == 4) ? 4'hF : (k < 4 ? 4'hE : 4'hD))) begin
                errors++; $display("FAIL midreset_an k=%0d got=%h exp=%h", k, an,
                                   (k == 0 || k == 4) ? 4'hF : (k < 4 ? 4'hE : 4'hD));
            end
            checks++;
            if (seg !== 7'h40 || err !== 1'b0) begin
                errors++; $display("FAIL midreset_cleared k=%0d got seg=%h err=%b exp seg=40 err=0", k, seg, err);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; load = 1'b0; bcd = '0; blank_en = 1'b0;
        load1 = 1'b0; bcd1 = '0; blank1 = 1'b0;
        test_reset;
        test_scan_idle;
        test_load_vectors;
        test_single_digit;
        test_random;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
